baud_gen_frac: RTL and testbench
================================

Name: baud_gen_frac

Overview:
Parametrised, runtime-programmable baud tick generator for the UART TX/RX pair. It produces an oversampled receive tick (rx_enb) and a bit-rate transmit tick (tx_enb) from one system clock. A fractional divisor accumulator gives accurate rates at non-integer ratios, for example 25 MHz / (115200 × 16) = 13.56. It adds features the fixed-divisor generator lacks: a config handshake, an RX phase resync at start-bit detection, an enable input, and an RX phase output.

Parameters:
CNT_W, 16, width of integer divisor and period counters
FRAC_W, 4, width of fractional divisor (units of 1/2^FRAC_W clock)
OVS, 16, RX oversample factor; power of 2, at least 2; PH_W = clog2(OVS)
RST_DIV_INT, 13, integer divisor after reset
RST_DIV_FRAC, 8, fractional divisor after reset (13 + 8/16 = 13.5)

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
en  in  1  tick enable; low freezes both chains
cfg_valid  in  1  new divisor offered
cfg_ready  out  1  generator can accept a divisor
cfg_div_int  in  CNT_W  integer oversample divisor
cfg_div_frac  in  FRAC_W  fractional oversample divisor
cfg_err  out  1  one-cycle pulse: offered divisor rejected
rx_resync  in  1  restart RX phase (start-bit edge)
rx_enb  out  1  oversample tick, 1 cycle wide
rx_phase  out  PH_W  index of current RX oversample tick
tx_enb  out  1  bit tick, 1 cycle wide

Behaviour:
- Single clock domain: clk. Reset is synchronous and active-high on rst.
- Reset state:
  - active divisor = RST_DIV_INT / RST_DIV_FRAC.
  - All counters, accumulators, carries and phases = 0.
  - cfg_ready = 1, cfg_err = 0, no pending configuration.
  - rx_enb and tx_enb are high in the first cycle after reset if en = 1.
- Fractional engine: two identical copies, an RX chain and a TX chain. Each has cnt[CNT_W], acc[FRAC_W], ext[1] and phase[PH_W].
  - Tick condition: cnt == 0 && en.
  - On a tick:
    - {c, acc_n} = acc + div_frac; acc <= acc_n; ext <= c.
    - phase <= phase + 1, modulo OVS.
  - Counting while en = 1:
    - if cnt == div_int - 1 + ext, then cnt <= 0; otherwise cnt <= cnt + 1.
    - ext is the value latched at the last tick.
  - Resulting period sequence for 13.5: 13, 14, 13, 14, ... with an exact average of div_int + div_frac/2^FRAC_W.
  - If div_frac = 0, every period equals div_int.
- Outputs:
  - rx_enb = RX-chain tick.
  - rx_phase = RX-chain phase register.
  - tx_enb = TX-chain tick && TX phase == 0, so the TX bit period averages OVS × divisor clocks (216 for defaults).
  - All outputs are decoded from registers gated by en. There is no other combinational input path.
- en = 0: all counters, accumulators, carries and phases hold. rx_enb = tx_enb = 0. Counting resumes unchanged when en returns to 1.
- rx_resync = 1 (acts regardless of en): RX chain cnt, acc, ext and phase <= 0. rx_enb fires in the next cycle if en = 1, with rx_phase = 0. The TX chain is unaffected.
- Config handshake:
  - A transfer occurs when cfg_valid && cfg_ready.
  - If cfg_div_int < 2: cfg_err pulses high for 1 cycle, nothing else changes, and cfg_ready stays 1.
  - Otherwise: the divisor is captured as pending and cfg_ready <= 0.
  - While cfg_ready = 0, cfg_valid is ignored.
- Apply of pending divisor:
  - Timing:
    - If en = 1, it is applied in the first cycle with tx_enb = 1 after capture. That tick is still emitted and counts as cycle 0 of the new configuration.
    - If en = 0, it is applied in the cycle after capture.
  - TX chain on apply: cnt <= 1 (cnt <= 0 if en = 0), acc <= 0, ext <= 0, phase <= 1 (0 if en = 0).
  - RX chain on apply: cnt, acc, ext and phase <= 0.
  - Active divisor <= pending; cfg_ready <= 1.
- Simultaneous events:
  - Apply and rx_resync in the same cycle: the RX chain goes to 0 (same outcome either way).
  - Capture and apply cannot coincide, because cfg_ready = 0 while a divisor is pending.
- rst mid-operation: any pending divisor is dropped and the block returns to the reset state, including the RST_* divisor.
- Width rules: the accumulator wraps modulo 2^FRAC_W and the carry is kept in ext. div_int is at most 2^CNT_W - 1. The limit div_int - 1 + ext always fits in CNT_W bits.

Test Plan:
- Reset, en = 1, defaults:
  - rx_enb at cycles 0, 13, 27, 40, 54, ... (periods alternate 13, 14).
  - tx_enb at cycles 0, 216, 432.
  - rx_phase counts 0..15 and wraps.
- Load 4/0 mid-run:
  - cfg_ready falls for one cycle after the transfer and stays low until the next tx_enb.
  - Afterwards, rx_enb period = 4 and tx_enb period = 64.
  - No double tick at the switchover.
- Offer cfg_div_int = 1 → cfg_err pulses for exactly 1 cycle, cfg_ready stays 1, periods unchanged (13.5 / 216).
- Assert rx_resync at rx_cnt = 7 → rx_enb in the next cycle with rx_phase = 0, then periods 13, 14, ... from there. tx_enb timing unchanged.
- Drop en for 50 cycles mid-period → no ticks during the gap. Afterwards the tick sequence continues exactly, shifted by 50 cycles.
- Pending 4/0, then rst pulse before apply → defaults restored (216-cycle tx_enb), cfg_ready = 1, pending divisor never applied.

Source files
------------

// File: rtl/baud_gen_frac.sv
// Fractional-divisor baud tick generator: oversampled RX tick, bit-rate TX tick,
// runtime divisor load with handshake, RX phase resync and tick enable.

module baud_gen_frac_chain #(
  parameter int unsigned CNT_W  = 16,
  parameter int unsigned FRAC_W = 4,
  parameter int unsigned PH_W   = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              en_i,
  input  logic              clr_i,
  input  logic              load_i,
  input  logic [CNT_W-1:0]  div_int_i,
  input  logic [FRAC_W-1:0] div_frac_i,
  output logic              tick_o,
  output logic [PH_W-1:0]   phase_o
);

  logic [CNT_W-1:0]  cnt_q, cnt_d, limit;
  logic [FRAC_W-1:0] acc_q, acc_d;
  logic              ext_q, ext_d;
  logic [PH_W-1:0]   phase_q, phase_d;
  logic              zero;

  assign zero    = (cnt_q == '0);
  assign tick_o  = zero && en_i;
  assign phase_o = phase_q;
  // Period end uses the carry latched at the previous tick; limit >= 1 since div_int >= 2.
  assign limit   = div_int_i - CNT_W'(1) + CNT_W'(ext_q);

  always_comb begin
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    ext_d   = ext_q;
    phase_d = phase_q;
    if (clr_i) begin
      cnt_d   = '0;
      acc_d   = '0;
      ext_d   = 1'b0;
      phase_d = '0;
    end else if (load_i) begin
      cnt_d   = CNT_W'(1);
      acc_d   = '0;
      ext_d   = 1'b0;
      phase_d = PH_W'(1);
    end else if (en_i) begin
      if (zero) begin
        {ext_d, acc_d} = {1'b0, acc_q} + {1'b0, div_frac_i};
        phase_d        = phase_q + PH_W'(1);
      end
      cnt_d = (cnt_q == limit) ? '0 : cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q   <= '0;
      acc_q   <= '0;
      ext_q   <= 1'b0;
      phase_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      ext_q   <= ext_d;
      phase_q <= phase_d;
    end
  end

endmodule

module baud_gen_frac #(
  parameter int unsigned CNT_W        = 16,
  parameter int unsigned FRAC_W       = 4,
  parameter int unsigned OVS          = 16,
  parameter int unsigned RST_DIV_INT  = 13,
  parameter int unsigned RST_DIV_FRAC = 8,
  parameter int unsigned PH_W         = $clog2(OVS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CNT_W-1:0]  cfg_div_int,
  input  logic [FRAC_W-1:0] cfg_div_frac,
  output logic              cfg_err,
  input  logic              rx_resync,
  output logic              rx_enb,
  output logic [PH_W-1:0]   rx_phase,
  output logic              tx_enb
);

  typedef enum logic {CFG_IDLE, CFG_PEND} cfg_state_t;

  cfg_state_t        state_q;
  logic [CNT_W-1:0]  div_int_q, pend_int_q;
  logic [FRAC_W-1:0] div_frac_q, pend_frac_q;
  logic              cfg_err_q;
  logic              accept, bad_div, apply;
  logic              tx_tick;
  logic [PH_W-1:0]   tx_phase;

  assign accept    = cfg_valid && (state_q == CFG_IDLE);
  assign bad_div   = (cfg_div_int < CNT_W'(2));
  assign tx_enb    = tx_tick && (tx_phase == '0);
  // With en low there is no tick to wait for, so a pending divisor lands at once.
  assign apply     = (state_q == CFG_PEND) && (!en || tx_enb);
  assign cfg_ready = (state_q == CFG_IDLE);
  assign cfg_err   = cfg_err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= CFG_IDLE;
      div_int_q   <= CNT_W'(RST_DIV_INT);
      div_frac_q  <= FRAC_W'(RST_DIV_FRAC);
      pend_int_q  <= '0;
      pend_frac_q <= '0;
      cfg_err_q   <= 1'b0;
    end else begin
      cfg_err_q <= accept && bad_div;
      case (state_q)
        CFG_IDLE: begin
          if (accept && !bad_div) begin
            pend_int_q  <= cfg_div_int;
            pend_frac_q <= cfg_div_frac;
            state_q     <= CFG_PEND;
          end
        end
        CFG_PEND: begin
          if (apply) begin
            div_int_q  <= pend_int_q;
            div_frac_q <= pend_frac_q;
            state_q    <= CFG_IDLE;
          end
        end
        default: state_q <= CFG_IDLE;
      endcase
    end
  end

  baud_gen_frac_chain #(
    .CNT_W  (CNT_W),
    .FRAC_W (FRAC_W),
    .PH_W   (PH_W)
  ) u_rx_chain (
    .clk_i      (clk),
    .rst_i      (rst),
    .en_i       (en),
    .clr_i      (rx_resync || apply),
    .load_i     (1'b0),
    .div_int_i  (div_int_q),
    .div_frac_i (div_frac_q),
    .tick_o     (rx_enb),
    .phase_o    (rx_phase)
  );

  // Applying on a live tick: that tick counts as cycle 0 of the new divisor.
  baud_gen_frac_chain #(
    .CNT_W  (CNT_W),
    .FRAC_W (FRAC_W),
    .PH_W   (PH_W)
  ) u_tx_chain (
    .clk_i      (clk),
    .rst_i      (rst),
    .en_i       (en),
    .clr_i      (apply && !en),
    .load_i     (apply && en),
    .div_int_i  (div_int_q),
    .div_frac_i (div_frac_q),
    .tick_o     (tx_tick),
    .phase_o    (tx_phase)
  );

endmodule

// File: tb/tb_baud_gen_frac.sv
// Randomized bench for baud_gen_frac against a countdown-based rate model,
// plus directed tick-time checks for defaults and a 4/0 divisor load.

module tb_baud_gen_frac;

  localparam int CNT_W  = 16;
  localparam int FRAC_W = 4;
  localparam int OVS    = 16;
  localparam int PH_W   = 4;
  localparam int FR     = 1 << FRAC_W;

  logic              clk = 1'b0;
  logic              rst, en, cfg_valid, rx_resync;
  logic [CNT_W-1:0]  cfg_div_int;
  logic [FRAC_W-1:0] cfg_div_frac;
  logic              cfg_ready, cfg_err, rx_enb, tx_enb;
  logic [PH_W-1:0]   rx_phase;

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model: cycles remaining until each chain's next tick.
  int rx_wait, rx_fs, rx_ph, tx_wait, tx_fs, tx_ph;
  int a_int, a_frac, p_int, p_frac;
  bit pend, err_e;

  int cyc;
  int tx_times[$];
  int rx_times[$];

  always #5 clk = ~clk;

  baud_gen_frac #(
    .CNT_W        (CNT_W),
    .FRAC_W       (FRAC_W),
    .OVS          (OVS),
    .RST_DIV_INT  (13),
    .RST_DIV_FRAC (8)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .cfg_valid    (cfg_valid),
    .cfg_ready    (cfg_ready),
    .cfg_div_int  (cfg_div_int),
    .cfg_div_frac (cfg_div_frac),
    .cfg_err      (cfg_err),
    .rx_resync    (rx_resync),
    .rx_enb       (rx_enb),
    .rx_phase     (rx_phase),
    .tx_enb       (tx_enb)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s at t=%0t: got %0d, expected %0d", tag, $time, got, exp);
  endtask

  task automatic model_reset();
    rx_wait = 0; rx_fs = 0; rx_ph = 0;
    tx_wait = 0; tx_fs = 0; tx_ph = 0;
    a_int = 13; a_frac = 8; p_int = 0; p_frac = 0;
    pend = 0; err_e = 0;
  endtask

  task automatic adv(inout int w, inout int fs, inout int ph);
    if (w == 0) begin
      fs = fs + a_frac;
      w  = a_int - 1 + fs / FR;
      fs = fs % FR;
      ph = (ph + 1) % OVS;
    end else begin
      w = w - 1;
    end
  endtask

  // Inputs are set at the falling edge before calling; checks, then advances the model.
  task automatic step();
    bit e_rx, e_tx, apply, acc;
    #1;
    e_rx = en && (rx_wait == 0);
    e_tx = en && (tx_wait == 0) && (tx_ph == 0);
    check("rx_enb", 32'(rx_enb), 32'(e_rx));
    check("rx_phase", 32'(rx_phase), 32'(rx_ph));
    check("tx_enb", 32'(tx_enb), 32'(e_tx));
    check("cfg_ready", 32'(cfg_ready), 32'(!pend));
    check("cfg_err", 32'(cfg_err), 32'(err_e));
    if (tx_enb === 1'b1) tx_times.push_back(cyc);
    if (rx_enb === 1'b1) rx_times.push_back(cyc);
    cyc++;
    if (rst) begin
      model_reset();
    end else begin
      apply = pend && (!en || e_tx);
      acc   = cfg_valid && !pend;
      err_e = acc && (int'(cfg_div_int) < 2);
      if (apply) begin
        tx_fs = 0;
        if (en) begin tx_wait = p_int - 1; tx_ph = 1; end
        else    begin tx_wait = 0;         tx_ph = 0; end
      end else if (en) begin
        adv(tx_wait, tx_fs, tx_ph);
      end
      if (rx_resync || apply) begin
        rx_wait = 0; rx_fs = 0; rx_ph = 0;
      end else if (en) begin
        adv(rx_wait, rx_fs, rx_ph);
      end
      if (apply) begin
        a_int = p_int; a_frac = p_frac; pend = 0;
      end else if (acc && int'(cfg_div_int) >= 2) begin
        pend = 1; p_int = int'(cfg_div_int); p_frac = int'(cfg_div_frac);
      end
    end
    @(negedge clk);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic offer(input int di, input int df);
    cfg_valid = 1'b1; cfg_div_int = CNT_W'(di); cfg_div_frac = FRAC_W'(df);
    step();
    cfg_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; cfg_valid = 1'b0; rx_resync = 1'b0;
    cfg_div_int = '0; cfg_div_frac = '0;
    model_reset();
    cyc = 0;
    repeat (2) @(negedge clk);
    step();
    rst = 1'b0;

    // Defaults from reset: tick times measured from the first cycle after reset.
    cyc = 0; tx_times.delete(); rx_times.delete();
    run(440);
    check("def_tx_count", 32'(tx_times.size()), 32'd3);
    if (tx_times.size() == 3) begin
      check("def_tx_t0", 32'(tx_times[0]), 32'd0);
      check("def_tx_t1", 32'(tx_times[1]), 32'd216);
      check("def_tx_t2", 32'(tx_times[2]), 32'd432);
    end
    if (rx_times.size() >= 5) begin
      check("def_rx_t1", 32'(rx_times[1]), 32'd13);
      check("def_rx_t2", 32'(rx_times[2]), 32'd27);
      check("def_rx_t3", 32'(rx_times[3]), 32'd40);
      check("def_rx_t4", 32'(rx_times[4]), 32'd54);
    end else begin
      check("def_rx_count", 32'(rx_times.size()), 32'd5);
    end

    // Load 4/0 mid-run: apply on the next bit tick, then 64-cycle bit period.
    offer(4, 0);
    tx_times.delete();
    run(300);
    if (tx_times.size() >= 2)
      check("load_tx_period", 32'(tx_times[tx_times.size()-1] - tx_times[tx_times.size()-2]), 32'd64);
    else
      check("load_tx_count", 32'(tx_times.size()), 32'd2);

    // Rejected divisor.
    offer(1, 3);
    run(250);

    // Resync and enable gap.
    run(5); rx_resync = 1'b1; step(); rx_resync = 1'b0;
    run(30);
    en = 1'b0; run(50); en = 1'b1;
    run(100);

    // Back to defaults, offer 4/0, reset before it can apply.
    rst = 1'b1; step(); rst = 1'b0;
    run(10);
    offer(4, 0);
    run(10);
    rst = 1'b1; step(); rst = 1'b0;
    cyc = 0; tx_times.delete();
    run(440);
    if (tx_times.size() >= 2)
      check("rst_drop_tx_period", 32'(tx_times[1] - tx_times[0]), 32'd216);
    else
      check("rst_drop_tx_count", 32'(tx_times.size()), 32'd2);

    // Randomized traffic.
    for (int i = 0; i < 4000; i++) begin
      en           = ($urandom % 8) != 0;
      rx_resync    = ($urandom % 40) == 0;
      cfg_valid    = ($urandom % 50) == 0;
      cfg_div_int  = CNT_W'($urandom_range(0, 6));
      cfg_div_frac = FRAC_W'($urandom % FR);
      rst          = ($urandom % 700) == 0;
      step();
    end
    rst = 1'b0; en = 1'b1; cfg_valid = 1'b0; rx_resync = 1'b0;
    run(20);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
